// File: rtl/mem_cycle_ctrl.sv
// External-memory cycle controller: splits one CPU word access into BUS_W-wide
// bus transfers (SETUP / STROBE / HOLD per lane), with wait states, READY and byte mode.
module mem_cycle_ctrl #(
  parameter int WORD_W      = 16,
  parameter int BUS_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk12,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              byte_mode,
  input  logic [0:ADDR_W-1] addr,
  input  logic [0:WORD_W-1] wdata,
  output logic [0:WORD_W-1] rdata,
  output logic              busy,
  output logic              done,
  output logic [0:ADDR_W-1] mem_addr,
  output logic              memen_n,
  output logic              dbin,
  output logic              we_n,
  output logic [0:BUS_W-1]  bus_out,
  output logic              bus_oe,
  input  logic [0:BUS_W-1]  bus_in,
  input  logic              ready
);

  localparam int LANES = WORD_W / BUS_W;
  localparam int LB    = $clog2(LANES);
  localparam int LBW   = (LB > 0) ? LB : 1;
  localparam int CW    = $clog2(WAIT_STATES + 2);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state, state_nx;
  logic                rd_q, rd_nx;
  logic                single_q, single_nx;
  logic [0:ADDR_W-1]   addr_q, addr_nx;
  logic [0:WORD_W-1]   wdata_q, wdata_nx;
  logic [0:WORD_W-1]   rbuf, rbuf_nx;
  logic [LBW-1:0]      lane, lane_nx;
  logic [CW-1:0]       wcnt, wcnt_nx;

  logic [0:WORD_W-1]   rdata_nx;
  logic                busy_nx, done_nx, memen_n_nx, dbin_nx, we_n_nx, bus_oe_nx;
  logic [0:ADDR_W-1]   mem_addr_nx;
  logic [0:BUS_W-1]    bus_out_nx;

  logic                go_setup, setup_rd;
  logic [LBW-1:0]      setup_lane;
  logic [0:ADDR_W-1]   setup_addr;
  logic [0:WORD_W-1]   setup_wdata;
  int unsigned         lane_base;

  // Lane index lives in the LSB-side address bits (highest indices in TI order).
  function automatic logic [LBW-1:0] addr_lane(input logic [0:ADDR_W-1] a);
    addr_lane = '0;
    for (int unsigned j = 0; j < LB; j++) addr_lane[j] = a[ADDR_W-1-j];
  endfunction

  function automatic logic [0:ADDR_W-1] lane_addr(input logic [0:ADDR_W-1] a,
                                                  input logic [LBW-1:0] l);
    lane_addr = a;
    for (int unsigned j = 0; j < LB; j++) lane_addr[ADDR_W-1-j] = l[j];
  endfunction

  function automatic logic [0:BUS_W-1] lane_slice(input logic [0:WORD_W-1] d,
                                                  input logic [LBW-1:0] l);
    int unsigned base;
    base = 32'(l) * 32'(BUS_W);
    lane_slice = d[base +: BUS_W];
  endfunction

  assign lane_base = 32'(lane) * 32'(BUS_W);

  always_comb begin
    state_nx    = state;
    rd_nx       = rd_q;
    single_nx   = single_q;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    rbuf_nx     = rbuf;
    lane_nx     = lane;
    wcnt_nx     = wcnt;
    rdata_nx    = rdata;
    busy_nx     = busy;
    done_nx     = 1'b0;
    mem_addr_nx = mem_addr;
    memen_n_nx  = memen_n;
    dbin_nx     = dbin;
    we_n_nx     = 1'b1;
    bus_out_nx  = bus_out;
    bus_oe_nx   = bus_oe;
    go_setup    = 1'b0;
    setup_rd    = rd_q;
    setup_lane  = lane;
    setup_addr  = addr_q;
    setup_wdata = wdata_q;

    case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          go_setup    = 1'b1;
          setup_rd    = rd_req;
          setup_addr  = addr;
          setup_wdata = rd_req ? wdata_q : wdata;
          setup_lane  = (byte_mode && (LANES > 1)) ? addr_lane(addr) : '0;
          rd_nx       = rd_req;
          single_nx   = byte_mode && (LANES > 1);
          addr_nx     = addr;
          wdata_nx    = setup_wdata;
          if (rd_req) rbuf_nx = '0;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        wcnt_nx  = '0;
        we_n_nx  = rd_q;
      end
      STROBE: begin
        we_n_nx = rd_q;
        if (wcnt == CW'(WAIT_STATES)) begin
          if (ready) begin
            state_nx = HOLD;
            we_n_nx  = 1'b1;
            if (rd_q) rbuf_nx[lane_base +: BUS_W] = bus_in;
          end
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      HOLD: begin
        if (single_q || lane == LBW'(LANES - 1)) begin
          state_nx   = IDLE;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          memen_n_nx = 1'b1;
          dbin_nx    = 1'b0;
          bus_oe_nx  = 1'b0;
          if (rd_q) rdata_nx = rbuf;
        end else begin
          go_setup   = 1'b1;
          setup_lane = lane + LBW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered, so SETUP values are loaded on the edge entering SETUP.
    if (go_setup) begin
      state_nx    = SETUP;
      lane_nx     = setup_lane;
      busy_nx     = 1'b1;
      memen_n_nx  = 1'b0;
      mem_addr_nx = lane_addr(setup_addr, setup_lane);
      dbin_nx     = setup_rd;
      bus_oe_nx   = !setup_rd;
      if (!setup_rd) bus_out_nx = lane_slice(setup_wdata, setup_lane);
    end
  end

  always_ff @(posedge clk12) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_q     <= 1'b0;
      single_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf     <= '0;
      lane     <= '0;
      wcnt     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      memen_n  <= 1'b1;
      dbin     <= 1'b0;
      we_n     <= 1'b1;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_q     <= rd_nx;
      single_q <= single_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      rbuf     <= rbuf_nx;
      lane     <= lane_nx;
      wcnt     <= wcnt_nx;
      rdata    <= rdata_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      mem_addr <= mem_addr_nx;
      memen_n  <= memen_n_nx;
      dbin     <= dbin_nx;
      we_n     <= we_n_nx;
      bus_out  <= bus_out_nx;
      bus_oe   <= bus_oe_nx;
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Scoreboard bench for mem_cycle_ctrl: expected completions and write transfers are
// queued when a request is driven and checked when done / we_n activity appears.
module tb_mem_cycle_ctrl;

  localparam int W         = 2;
  localparam int LANE_CLKS = W + 3;

  logic        clk12 = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req, byte_mode, ready;
  logic [15:0] addr, wdata, rdata, mem_addr;
  logic        busy, done, memen_n, dbin, we_n, bus_oe;
  logic [7:0]  bus_out, bus_in;

  typedef struct { bit rd; logic [15:0] rdata; int cyc; int we_low; } txn_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } xfer_t;

  txn_t  sb[$];
  xfer_t wq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  mem_cycle_ctrl #(.WORD_W(16), .BUS_W(8), .ADDR_W(16), .WAIT_STATES(W)) dut (
    .clk12(clk12), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
    .byte_mode(byte_mode), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .mem_addr(mem_addr), .memen_n(memen_n),
    .dbin(dbin), .we_n(we_n), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .ready(ready)
  );

  always #5 clk12 = ~clk12;
  always @(posedge clk12) cyc <= cyc + 1;

  // Memory contents seen on the pads during reads.
  function automatic logic [7:0] rd_val(input logic [15:0] a);
    case (a)
      16'h2000: return 8'h12;
      16'h2001: return 8'h34;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign bus_in = rd_val(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a falling edge; request is sampled at the next rising edge.
  task automatic do_req(input bit rd, input bit wr, input bit bm, input logic [15:0] a,
                        input logic [15:0] wd, input int extra);
    txn_t        t;
    int          n;
    logic [15:0] base;
    n    = bm ? 1 : 2;
    base = {a[15:1], 1'b0};
    rd_req = rd; wr_req = wr; byte_mode = bm; addr = a; wdata = wd;
    t.rd     = rd;
    t.cyc    = cyc + 1 + n * LANE_CLKS + extra;
    t.we_low = rd ? 0 : n * (W + 1) + extra;
    if (bm) t.rdata = a[0] ? {8'h00, rd_val(a)} : {rd_val(a), 8'h00};
    else    t.rdata = {rd_val(base), rd_val(base | 16'h1)};
    sb.push_back(t);
    if (!rd) begin
      if (bm) wq.push_back('{addr: a, data: (a[0] ? wd[7:0] : wd[15:8])});
      else begin
        wq.push_back('{addr: base, data: wd[15:8]});
        wq.push_back('{addr: base | 16'h1, data: wd[7:0]});
      end
    end
    @(negedge clk12);
    rd_req = 1'b0; wr_req = 1'b0;
    addr = 16'($urandom); wdata = 16'($urandom); byte_mode = 1'($urandom);
    check("busy_start", busy, 1);
    check("memen_start", memen_n, 0);
    check("dbin_start", dbin, rd);
    if (extra > 0) begin
      ready = 1'b0;
      repeat (extra + 3) @(negedge clk12);
      ready = 1'b1;
    end
    while (cyc < t.cyc) @(negedge clk12);
  endtask

  initial begin : monitor
    txn_t  t;
    xfer_t x;
    int    we_low  = 0;
    bit    prev_we = 1'b1;
    forever begin
      @(negedge clk12);
      if (!reset_n) begin
        we_low  = 0;
        prev_we = 1'b1;
      end else begin
        if (we_n === 1'b0) we_low++;
        if (we_n === 1'b0 && prev_we) begin
          if (wq.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            x = wq.pop_front();
            check("wr_addr", mem_addr, x.addr);
            check("wr_data", bus_out, x.data);
            check("wr_oe", bus_oe, 1);
            check("wr_memen", memen_n, 0);
          end
        end
        prev_we = (we_n !== 1'b0);
        if (done === 1'b1) begin
          if (sb.size() == 0) check("done_unexpected", 1, 0);
          else begin
            t = sb.pop_front();
            check("done_cycle", cyc, t.cyc);
            check("we_low_clks", we_low, t.we_low);
            if (t.rd) check("rdata", rdata, t.rdata);
            check("done_busy", busy, 0);
            check("done_memen", memen_n, 1);
            check("done_oe", bus_oe, 0);
          end
          we_low = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e;
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; byte_mode = 1'b0;
    addr = '0; wdata = '0; ready = 1'b1;
    repeat (3) @(negedge clk12);
    check("rst_busy", busy, 0);
    check("rst_memen", memen_n, 1);
    check("rst_we", we_n, 1);
    check("rst_dbin", dbin, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_bus_out", bus_out, 0);
    reset_n = 1'b1;

    do_req(1, 0, 0, 16'h2000, 16'h0000, 0);   // word read -> 0x1234
    do_req(0, 1, 0, 16'h3000, 16'hC003, 0);   // word write C0 then 03
    do_req(1, 0, 0, 16'h2001, 16'h0000, 4);   // four ready=0 samples
    do_req(1, 1, 0, 16'h4002, 16'h9999, 0);   // read wins, write dropped
    do_req(0, 1, 1, 16'h1001, 16'hAB55, 0);   // byte write lane 1
    do_req(1, 0, 1, 16'h2001, 16'h0000, 0);   // byte read lane 1
    do_req(1, 0, 1, 16'h2000, 16'h0000, 0);   // byte read lane 0
    do_req(0, 1, 1, 16'h1000, 16'hAB55, 1);
    do_req(0, 1, 0, 16'h6001, 16'h5AA5, 0);
    do_req(1, 0, 0, 16'h2000, 16'h0000, 0);   // leaves rdata nonzero

    // Reset during lane-1 STROBE of a word write.
    e = cyc + 1;
    rd_req = 1'b0; wr_req = 1'b1; byte_mode = 1'b0; addr = 16'h5000; wdata = 16'hBEEF;
    wq.push_back('{addr: 16'h5000, data: 8'hBE});
    wq.push_back('{addr: 16'h5001, data: 8'hEF});
    @(negedge clk12);
    wr_req = 1'b0;
    while (cyc < e + 6) @(negedge clk12);
    #1 reset_n = 1'b0;
    @(negedge clk12);
    check("mid_rst_we", we_n, 1);
    check("mid_rst_memen", memen_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_oe", bus_oe, 0);
    check("mid_rst_rdata", rdata, 0);
    #1 reset_n = 1'b1;
    @(negedge clk12);
    check("post_rst_done", done, 0);
    do_req(1, 0, 0, 16'h2000, 16'h0000, 0);

    for (int i = 0; i < 8; i++) begin
      bit rd;
      rd = 1'($urandom);
      do_req(rd, !rd, 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
    end

    repeat (20) @(negedge clk12);
    check("sb_drained", sb.size(), 0);
    check("wq_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
